// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter/sequencer for a single-port, combinational-read data memory.
// Optional per-port ack counters are compiled in when MEM_ARB_STATS_EN is defined.
module mem_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_cnt0,
  output logic [15:0]       stat_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t              state_q;
  logic                last_grant_q;
  logic                win_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                ack0_q;
  logic                ack1_q;
  logic [DATA_W-1:0]   rdata0_q;
  logic [DATA_W-1:0]   rdata1_q;

  logic                grant_valid_d;
  logic                grant_d;

  // On a tie the port that did not win last time is served.
  always_comb begin
    grant_valid_d = req0 | req1;
    grant_d       = 1'b0;
    if (req0 && req1) begin
      grant_d = ~last_grant_q;
    end else if (req1) begin
      grant_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      win_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_valid_d) begin
            win_q   <= grant_d;
            we_q    <= grant_d ? we1 : we0;
            addr_q  <= grant_d ? addr1 : addr0;
            wdata_q <= grant_d ? wdata1 : wdata0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (!we_q) begin
            if (win_q) begin
              rdata1_q <= mem_read_data;
            end else begin
              rdata0_q <= mem_read_data;
            end
          end
          ack0_q  <= ~win_q;
          ack1_q  <= win_q;
          state_q <= DONE;
        end
        DONE: begin
          last_grant_q <= win_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write strobe is combinational so a reset arriving mid-access blocks the store.
  assign mem_write      = (state_q == ISSUE) & we_q & ~rst;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign busy           = (state_q != IDLE);
  assign ack0           = ack0_q;
  assign ack1           = ack1_q;
  assign rdata0         = rdata0_q;
  assign rdata1         = rdata1_q;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_cnt0_q;
  logic [15:0] stat_cnt1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cnt0_q <= '0;
      stat_cnt1_q <= '0;
    end else begin
      if (ack0_q && stat_cnt0_q != 16'hFFFF) begin
        stat_cnt0_q <= stat_cnt0_q + 16'd1;
      end
      if (ack1_q && stat_cnt1_q != 16'hFFFF) begin
        stat_cnt1_q <= stat_cnt1_q + 16'd1;
      end
    end
  end

  assign stat_cnt0 = stat_cnt0_q;
  assign stat_cnt1 = stat_cnt1_q;
`endif

endmodule
